// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder sequencer. Drives an external 1-bit
//               full-adder cell LSB first, one bit per clock, and collects
//               sum/carry into a WIDTH-bit result with start/busy/done
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_f,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: the adder cell is fed only while RUN, otherwise held at zero.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    fa_a  = 1'b0;
    fa_b  = 1'b0;
    fa_ci = 1'b0;
    case (state)
      S_RUN: begin
        busy  = 1'b1;
        fa_a  = sa[0];
        fa_b  = sb[0];
        fa_ci = cy;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture on accepted start, then one bit per RUN edge.
  // sum/cout are not cleared on start; the shift overwrites every bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cy  <= cin;
            cnt <= '0;
          end
        end
        S_RUN: begin
          sum <= {fa_f, sum[WIDTH-1:1]};
          cy  <= fa_c;
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          if (last_bit) begin
            cout <= fa_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl with a behavioural
//               1-bit full adder closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             fa_a, fa_b, fa_ci, fa_f, fa_c;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_ci (fa_ci),
    .fa_f  (fa_f),
    .fa_c  (fa_c),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Full-adder cell
  assign {fa_c, fa_f} = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_ci};

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full operation starting just after a rising edge in IDLE; ends one
  // cycle after the done pulse, back in IDLE.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input bit poke,
                        input string tag);
    logic c;
    c = vc;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      chk({tag, " run bit"}, 32'({busy, done, fa_a, fa_b, fa_ci}),
          32'({1'b1, 1'b0, va[i], vb[i], c}));
      c = (va[i] & vb[i]) | (va[i] & c) | (vb[i] & c);
      if (poke) begin
        start = 1'($urandom);
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " done ctl"}, 32'({busy, done, fa_a, fa_b, fa_ci}), 32'(5'b11000));
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    @(posedge clk); #1;
    chk({tag, " idle ctl"}, 32'({busy, done, fa_a, fa_b, fa_ci}), 32'(5'b00000));
    chk({tag, " held"}, 32'({cout, sum}), 32'({ec, es}));
  endtask

  initial begin
    int k1, k2, nd;
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rc;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[9] = '{8'hC3, 8'h5E, 1'b0, 8'h21, 1'b1};

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset outputs", 32'({busy, done, fa_a, fa_b, fa_ci, cout, sum}), 32'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle", 32'({busy, done, fa_a, fa_b, fa_ci, cout, sum}), 32'(0));

    // Directed table
    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sum, vecs[v].cout, 1'b0,
             $sformatf("vec%0d", v));
    end

    // start held high, operands disturbed while running
    k1 = 0; k2 = 0; nd = 0;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (nd == 1) k1 = k;
        else if (nd == 2) k2 = k;
        chk("held-start sum", 32'({cout, sum}), 32'(9'h003));
      end
      if (busy && !done) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end else begin
        a = 8'h01; b = 8'h02; cin = 1'b0;
      end
    end
    start = 1'b0;
    chk("held-start done count", 32'(nd), 32'(2));
    chk("held-start first done", 32'(k1), 32'(9));
    chk("held-start second done", 32'(k2), 32'(19));
    @(posedge clk); #1;
    chk("held-start idle", 32'({busy, done}), 32'(0));

    // Reset in the middle of RUN
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre-abort busy", 32'({busy, done}), 32'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk("abort immediate", 32'({busy, done, fa_a, fa_b, fa_ci, cout, sum}), 32'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("no activity after abort", 32'(nd), 32'(0));
    chk("abort result cleared", 32'({cout, sum}), 32'(0));
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, "after-abort");

    // Random operands with start noise during RUN
    for (int r = 0; r < 1000; r++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      run_op(ra, rb, rc, ref9[7:0], ref9[8], 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
